// File: rtl/acc_bank.sv
// Accumulator bank with single-cycle LOAD/ADD/SUB/CLR and a multi-cycle shift-add MUL.
// Optional build macro ACC_SATURATE_EN switches ADD/SUB/MUL from wrap-around to clamping.
module acc_bank #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned NUM_ACC = 4,
   parameter int unsigned ADDR_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              carry,
   output logic              zero
);

   localparam int unsigned PROD_W = 2 * DATA_W;
   localparam int unsigned CNT_W  = $clog2(DATA_W + 1);

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_MUL_RUN = 1'b1;

   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_CLR  = 3'b100;
   localparam logic [2:0] OP_MUL  = 3'b101;

   logic [DATA_W-1:0] r_acc [NUM_ACC];
   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic              r_busy;
   logic              r_done;
   logic              r_carry;
   logic              r_zero;
   logic [PROD_W-1:0] r_mcand;
   logic [DATA_W-1:0] r_mplier;
   logic [PROD_W-1:0] r_prod;
   logic [ADDR_W-1:0] r_tgt;
   logic              r_tgt_ok;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_accept;
   logic              w_mul_start;
   logic              w_last;
   logic [DATA_W-1:0] w_op_acc;
   logic              w_addr_ok;
   logic [DATA_W-1:0] w_rd;
   logic [PROD_W-1:0] w_prod_step;
   logic              w_prod_hi_nz;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W-1:0] w_diff;
   logic              w_borrow;
   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [DATA_W-1:0] w_wr_val;
   logic              w_carry_val;
   logic              w_done_nxt;

   assign w_accept    = op_valid && !r_busy;
   assign w_mul_start = w_accept && (op == OP_MUL);
   assign w_last      = (r_state == S_MUL_RUN) && (r_cnt == CNT_W'(DATA_W - 1));
   assign w_prod_step = r_prod + (r_mplier[0] ? r_mcand : '0);
   assign w_prod_hi_nz = |w_prod_step[PROD_W-1:DATA_W];

   assign op_ready = !r_busy;
   assign busy     = r_busy;
   assign done     = r_done;
   assign carry    = r_carry;
   assign zero     = r_zero;
   assign rd_data  = w_rd;

   // Address decode for the operand read and the external read port; out-of-range reads 0.
   always_comb begin
      w_op_acc  = '0;
      w_addr_ok = 1'b0;
      w_rd      = '0;
      for (int unsigned i = 0; i < NUM_ACC; i++) begin
         if (addr == ADDR_W'(i)) begin
            w_op_acc  = r_acc[i];
            w_addr_ok = 1'b1;
         end
         if (rd_addr == ADDR_W'(i)) begin
            w_rd = r_acc[i];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (w_mul_start) w_state_nxt = S_MUL_RUN;
         S_MUL_RUN: if (w_last)      w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Write-back selection: MUL completion has priority since requests are blocked while busy.
   always_comb begin
      w_wr_en     = 1'b0;
      w_wr_addr   = addr;
      w_wr_val    = '0;
      w_carry_val = r_carry;
      w_done_nxt  = 1'b0;
      w_sum       = {1'b0, w_op_acc} + {1'b0, in_data};
      w_diff      = w_op_acc - in_data;
      w_borrow    = in_data > w_op_acc;
      if (r_state == S_MUL_RUN) begin
         if (w_last) begin
            w_done_nxt  = 1'b1;
            w_wr_en     = r_tgt_ok;
            w_wr_addr   = r_tgt;
            w_carry_val = w_prod_hi_nz;
            w_wr_val    = w_prod_step[DATA_W-1:0];
`ifdef ACC_SATURATE_EN
            if (w_prod_hi_nz) w_wr_val = '1;
`endif
         end
      end else if (op_valid) begin
         case (op)
            OP_LOAD: begin
               w_done_nxt = 1'b1;
               w_wr_en    = w_addr_ok;
               w_wr_val   = in_data;
            end
            OP_ADD: begin
               w_done_nxt  = 1'b1;
               w_wr_en     = w_addr_ok;
               w_carry_val = w_sum[DATA_W];
               w_wr_val    = w_sum[DATA_W-1:0];
`ifdef ACC_SATURATE_EN
               if (w_sum[DATA_W]) w_wr_val = '1;
`endif
            end
            OP_SUB: begin
               w_done_nxt  = 1'b1;
               w_wr_en     = w_addr_ok;
               w_carry_val = w_borrow;
               w_wr_val    = w_diff;
`ifdef ACC_SATURATE_EN
               if (w_borrow) w_wr_val = '0;
`endif
            end
            OP_CLR: begin
               w_done_nxt  = 1'b1;
               w_wr_en     = w_addr_ok;
               w_carry_val = 1'b0;
               w_wr_val    = '0;
            end
            default: begin
               w_done_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Datapath registers: accumulators, flags and the shift-add multiplier.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_tgt    <= '0;
         r_tgt_ok <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_done <= w_done_nxt;
         if (w_wr_en) begin
            r_carry <= w_carry_val;
            r_zero  <= (w_wr_val == '0);
         end
         for (int unsigned i = 0; i < NUM_ACC; i++) begin
            if (w_wr_en && (w_wr_addr == ADDR_W'(i))) r_acc[i] <= w_wr_val;
         end
         if (w_mul_start) begin
            r_mcand  <= {{DATA_W{1'b0}}, w_op_acc};
            r_mplier <= in_data;
            r_prod   <= '0;
            r_tgt    <= addr;
            r_tgt_ok <= w_addr_ok;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
         end else if (r_state == S_MUL_RUN) begin
            r_prod   <= w_prod_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) r_busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench for acc_bank: a 4-entry and a 3-entry instance share stimulus
// and are checked against an integer-arithmetic reference model.
module tb_acc_bank;

   localparam int unsigned DW   = 8;
   localparam int unsigned AW   = 2;
   localparam int          MAXV = 255;

   logic          clk;
   logic          rst;
   logic          op_valid;
   logic [2:0]    op;
   logic [AW-1:0] addr;
   logic [DW-1:0] in_data;
   logic [AW-1:0] rd_addr;

   logic          ready_a, busy_a, done_a, carry_a, zero_a;
   logic [DW-1:0] rd_a;
   logic          ready_b, busy_b, done_b, carry_b, zero_b;
   logic [DW-1:0] rd_b;

   int n_checks;
   int n_errors;

   int m_acc   [2][4];
   int m_nacc  [2];
   bit m_carry [2];
   bit m_zero  [2];

   acc_bank #(.DATA_W(DW), .NUM_ACC(4), .ADDR_W(AW)) u_dut_a (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(ready_a), .op(op),
      .addr(addr), .in_data(in_data), .rd_addr(rd_addr), .rd_data(rd_a),
      .busy(busy_a), .done(done_a), .carry(carry_a), .zero(zero_a)
   );

   acc_bank #(.DATA_W(DW), .NUM_ACC(3), .ADDR_W(AW)) u_dut_b (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(ready_b), .op(op),
      .addr(addr), .in_data(in_data), .rd_addr(rd_addr), .rd_data(rd_b),
      .busy(busy_b), .done(done_b), .carry(carry_b), .zero(zero_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int m_rd(input int inst, input int a);
      return (a < m_nacc[inst]) ? m_acc[inst][a] : 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) m_acc[k][j] = 0;
         m_carry[k] = 1'b0;
         m_zero[k]  = 1'b0;
      end
   endtask

   // Reference semantics computed with plain integer arithmetic.
   task automatic model_op(input int inst, input int o, input int a, input int d);
      int cur, res, full;
      bit c;
      cur = m_rd(inst, a);
      c   = m_carry[inst];
      case (o)
         1: res = d;
         2: begin
            full = cur + d;
            c    = full > MAXV;
            res  = full & MAXV;
`ifdef ACC_SATURATE_EN
            if (c) res = MAXV;
`endif
         end
         3: begin
            c   = d > cur;
            res = (cur - d) & MAXV;
`ifdef ACC_SATURATE_EN
            if (c) res = 0;
`endif
         end
         4: begin
            res = 0;
            c   = 1'b0;
         end
         5: begin
            full = cur * d;
            c    = full > MAXV;
            res  = full & MAXV;
`ifdef ACC_SATURATE_EN
            if (c) res = MAXV;
`endif
         end
         default: return;
      endcase
      if (a < m_nacc[inst]) begin
         m_acc[inst][a] = res;
         m_carry[inst]  = c;
         m_zero[inst]   = (res == 0);
      end
   endtask

   task automatic check_outs(input string tag, input bit exp_done);
      check({tag, ":rd_a"},    32'(rd_a),    32'(m_rd(0, int'(rd_addr))));
      check({tag, ":rd_b"},    32'(rd_b),    32'(m_rd(1, int'(rd_addr))));
      check({tag, ":done_a"},  32'(done_a),  32'(exp_done));
      check({tag, ":done_b"},  32'(done_b),  32'(exp_done));
      check({tag, ":carry_a"}, 32'(carry_a), 32'(m_carry[0]));
      check({tag, ":carry_b"}, 32'(carry_b), 32'(m_carry[1]));
      check({tag, ":zero_a"},  32'(zero_a),  32'(m_zero[0]));
      check({tag, ":zero_b"},  32'(zero_b),  32'(m_zero[1]));
      check({tag, ":busy_a"},  32'(busy_a),  32'(0));
      check({tag, ":busy_b"},  32'(busy_b),  32'(0));
   endtask

   task automatic sweep(input string tag);
      for (int j = 0; j < 4; j++) begin
         rd_addr = AW'(j);
         #1;
         check($sformatf("%s:sweep_a%0d", tag, j), 32'(rd_a), 32'(m_rd(0, j)));
         check($sformatf("%s:sweep_b%0d", tag, j), 32'(rd_b), 32'(m_rd(1, j)));
      end
   endtask

   task automatic single_op(input string tag, input int o, input int a, input int d);
      @(negedge clk);
      op_valid = 1'b1;
      op       = 3'(o);
      addr     = AW'(a);
      in_data  = DW'(d);
      rd_addr  = AW'(a);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      model_op(0, o, a, d);
      model_op(1, o, a, d);
      check_outs(tag, (o >= 1) && (o <= 4));
   endtask

   task automatic mul_op(input string tag, input int a, input int d, input bit intr);
      int pre_a, pre_b, busy_cnt;
      pre_a    = m_rd(0, a);
      pre_b    = m_rd(1, a);
      busy_cnt = 0;
      @(negedge clk);
      op_valid = 1'b1;
      op       = 3'd5;
      addr     = AW'(a);
      in_data  = DW'(d);
      rd_addr  = AW'(a);
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      for (int k = 1; k <= int'(DW); k++) begin
         @(negedge clk);
         if (busy_a) busy_cnt++;
         check({tag, ":ready_a"}, 32'(ready_a), 32'(0));
         check({tag, ":busy_b"},  32'(busy_b),  32'(1));
         check({tag, ":pre_a"},   32'(rd_a),    32'(pre_a));
         check({tag, ":pre_b"},   32'(rd_b),    32'(pre_b));
         if (intr && k == 3) begin
            op_valid = 1'b1;
            op       = 3'd2;
            addr     = AW'(3);
            in_data  = 8'h11;
         end
         @(posedge clk);
         #1;
         op_valid = 1'b0;
      end
      check({tag, ":busy_cycles"}, 32'(busy_cnt), 32'(DW));
      model_op(0, 5, a, d);
      model_op(1, 5, a, d);
      check_outs(tag, 1'b1);
      check({tag, ":ready_after"}, 32'(ready_a), 32'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_nacc[0] = 4;
      m_nacc[1] = 3;
      model_reset();
      rst      = 1'b0;
      op_valid = 1'b0;
      op       = 3'd0;
      addr     = '0;
      in_data  = '0;
      rd_addr  = '0;

      // Reset state, with op_valid asserted while in reset
      repeat (2) @(posedge clk);
      op_valid = 1'b1;
      op       = 3'd1;
      in_data  = 8'hAA;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      check("rst:busy",  32'(busy_a),  32'(0));
      check("rst:ready", 32'(ready_a), 32'(1));
      @(negedge clk);
      rst = 1'b1;
      check_outs("rst", 1'b0);
      sweep("rst");

      // LOAD acc1, single done pulse
      single_op("load1", 1, 1, 'h3C);
      check("load1:lit", 32'(rd_a), 32'h3C);
      single_op("nop1", 0, 1, 'h99);
      check("nop1:done_lit", 32'(done_a), 32'(0));

      // ADD carry, SUB to zero, SUB borrow
      single_op("load0", 1, 0, 'hF0);
      single_op("add0", 2, 0, 'h20);
      check("add0:lit", 32'(rd_a), 32'h10);
      check("add0:c", 32'(carry_a), 32'(1));
      single_op("sub0", 3, 0, 'h10);
      check("sub0:z", 32'(zero_a), 32'(1));
      single_op("sub1", 3, 0, 'h01);
`ifdef ACC_SATURATE_EN
      check("sub1:lit", 32'(rd_a), 32'h00);
`else
      check("sub1:lit", 32'(rd_a), 32'hFF);
`endif
      check("sub1:c", 32'(carry_a), 32'(1));
      single_op("rsvd", 6, 0, 'h12);
      single_op("rsvd7", 7, 1, 'h34);

      // MUL 0x0D x 0x0B
      single_op("load2", 1, 2, 'h0D);
      mul_op("mul2", 2, 'h0B, 1'b0);
      check("mul2:lit", 32'(rd_a), 32'h8F);

      // MUL overflow with an ignored ADD to acc3 mid-run
      single_op("load3", 1, 3, 'h77);
      single_op("load1b", 1, 1, 'h20);
      mul_op("mulov", 1, 'h10, 1'b1);
`ifdef ACC_SATURATE_EN
      check("mulov:lit", 32'(rd_a), 32'hFF);
`else
      check("mulov:lit", 32'(rd_a), 32'h00);
`endif
      sweep("mulov");
      check("mulov:acc3", 32'(rd_a), 32'h77);

      // Out-of-range on the 3-entry instance
      single_op("oor", 1, 3, 'h55);
      check("oor:done_b", 32'(done_b), 32'(1));
      check("oor:rd_b", 32'(rd_b), 32'(0));
      sweep("oor");

      // Reset in the middle of a MUL
      single_op("load2r", 1, 2, 'h09);
      @(negedge clk);
      op_valid = 1'b1;
      op       = 3'd5;
      addr     = AW'(2);
      in_data  = 8'h07;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      model_reset();
      check("mrst:busy_a", 32'(busy_a), 32'(0));
      check("mrst:busy_b", 32'(busy_b), 32'(0));
      check("mrst:done",   32'(done_a), 32'(0));
      check("mrst:carry",  32'(carry_a), 32'(0));
      sweep("mrst");
      @(posedge clk);
      #2;
      rst = 1'b1;
      single_op("postrst", 1, 0, 'h42);
      check("postrst:lit", 32'(rd_a), 32'h42);
      repeat (12) @(posedge clk);
      #1;
      sweep("postmul");

      // Randomized operation stream against the model
      for (int n = 0; n < 80; n++) begin
         int o, a, d;
         o = int'($urandom_range(0, 7));
         a = int'($urandom_range(0, 3));
         d = int'($urandom_range(0, 255));
         if (($urandom_range(0, 3) == 0) && (o != 5)) d = 0;
         if (o == 5) mul_op($sformatf("rnd%0d", n), a, d, 1'($urandom_range(0, 1)));
         else        single_op($sformatf("rnd%0d", n), o, a, d);
      end
      sweep("final");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
